dt_timestamp_gen: RTL

Upstream stage of the time-parameter sequencer. It converts successive integer measurement timestamps into an IEEE-754 double `delta_t` in seconds and issues the 1-cycle `start` pulse that launches the dt-power/coefficient sequence. It handles the first sample, counter wrap-around, duplicate timestamps, oversize gaps and overrun. It reuses one `fp_multiplier` (valid/finish handshake) for the tick-to-seconds scaling.

---
 rtl/kf_fp_pkg.sv | 23 ++
 rtl/fp_multiplier.sv | 86 ++++++++
 rtl/uint_to_fp64.sv | 30 +++
 rtl/dt_timestamp_gen.sv | 126 ++++++++++++
 4 files changed

// File: rtl/kf_fp_pkg.sv
// Shared floating-point package for the time-parameter sequencer.
// Holds the timestamp FSM state type, IEEE-754 double field constants and
// commonly used double constants.
package kf_fp_pkg;

    // Timestamp generator FSM states
    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_ISSUE,
        S_WAIT
    } ts_state_e;

    // IEEE-754 double layout
    localparam int unsigned FP_MANT_W   = 52;
    localparam int unsigned FP_EXP_W    = 11;
    localparam int unsigned FP_EXP_BIAS = 1023;

    // Double constants
    localparam logic [63:0] C_1E_6 = 64'h3EB0_C6F7_A0B5_ED8D;
    localparam logic [63:0] C_1_0  = 64'h3FF0_0000_0000_0000;

endpackage

// File: rtl/fp_multiplier.sv
// Two-stage pipelined IEEE-754 double multiplier, round-to-nearest-even.
// Subnormal inputs are treated as zero, underflow flushes to signed zero and
// overflow saturates to signed infinity; NaN inputs are not distinguished.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   valid       in   start a multiply of a * b
//   a, b        in   double operands, sampled when valid is high
//   finish      out  1-cycle pulse, result holds the product
//   result      out  double product, held until the next finish
module fp_multiplier import kf_fp_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        finish,
    output logic [63:0] result
);

    logic               s1_vld;
    logic               s1_sign;
    logic               s1_zero;
    logic signed [12:0] s1_exp;
    logic [105:0]       s1_prod;

    logic               norm;
    logic [51:0]        mant_raw;
    logic               guard;
    logic               sticky;
    logic [52:0]        mant_r;
    logic signed [12:0] exp_f;
    logic [63:0]        y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_exp  <= '0;
            s1_prod <= '0;
        end else begin
            s1_vld <= valid;
            if (valid) begin
                s1_sign <= a[63] ^ b[63];
                s1_zero <= (a[62:52] == '0) || (b[62:52] == '0);
                s1_exp  <= $signed(13'(a[62:52]) + 13'(b[62:52]) - 13'd1023);
                s1_prod <= 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
            end
        end
    end

    always_comb begin
        // Product of two [1,2) significands lies in [1,4)
        norm = s1_prod[105];
        if (norm) begin
            mant_raw = s1_prod[104:53];
            guard    = s1_prod[52];
            sticky   = |s1_prod[51:0];
        end else begin
            mant_raw = s1_prod[103:52];
            guard    = s1_prod[51];
            sticky   = |s1_prod[50:0];
        end
        mant_r = {1'b0, mant_raw} + 53'(guard & (sticky | mant_raw[0]));
        // Rounding carry out of the mantissa bumps the exponent; mantissa wraps to 0
        exp_f  = s1_exp + $signed({12'b0, norm}) + $signed({12'b0, mant_r[52]});
        if (s1_zero || exp_f <= 13'sd0) begin
            y = {s1_sign, 63'b0};
        end else if (exp_f >= 13'sd2047) begin
            y = {s1_sign, 11'h7FF, 52'b0};
        end else begin
            y = {s1_sign, exp_f[10:0], mant_r[51:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish <= 1'b0;
            result <= '0;
        end else begin
            finish <= s1_vld;
            if (s1_vld) result <= y;
        end
    end

endmodule

// File: rtl/uint_to_fp64.sv
// Combinational unsigned integer to IEEE-754 double converter.
// Exact for inputs up to 53 bits wide (TS_W legal range 2..52).
// Ports:
//   x  in   TS_W  unsigned integer
//   y  out  64    double, +0.0 when x is zero
module uint_to_fp64 import kf_fp_pkg::*; #(
    parameter int unsigned TS_W = 32
) (
    input  logic [TS_W-1:0] x,
    output logic [63:0]     y
);

    logic [5:0]  msb;
    logic [52:0] ext;

    always_comb begin
        msb = '0;
        for (int i = 0; i < TS_W; i++) begin
            if (x[i]) msb = 6'(i);
        end
        // Shift the leading one up to bit 52; bits below it form the mantissa
        ext = 53'(x) << (6'd52 - msb);
        if (x == '0) begin
            y = '0;
        end else begin
            y = {1'b0, 11'(11'(FP_EXP_BIAS) + 11'(msb)), ext[FP_MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/dt_timestamp_gen.sv
// Converts successive measurement timestamps into a double delta_t in seconds
// and pulses dt_start to launch the dt-power/coefficient sequence.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   meas_valid   in   1-cycle pulse, new timestamp on meas_ts
//   meas_ts      in   free-running tick count
//   delta_t      out  dt in seconds (double), held until next update
//   dt_ticks     out  tick delta used for delta_t (after clamp)
//   dt_start     out  1-cycle pulse, delta_t valid
//   busy         out  conversion in progress
//   clamp_err    out  1-cycle pulse, delta clamped to DT_MAX_TICKS
//   dup_err      out  1-cycle pulse, zero delta, sample discarded
//   ovr_err      out  1-cycle pulse, sample arrived while busy and dropped
module dt_timestamp_gen import kf_fp_pkg::*; #(
    parameter int unsigned        TS_W         = 32,
    parameter int unsigned        DWIDTH       = 64,
    parameter logic [DWIDTH-1:0]  TICK_SEC     = C_1E_6,
    parameter int unsigned        DT_MAX_TICKS = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              meas_valid,
    input  logic [TS_W-1:0]   meas_ts,
    output logic [DWIDTH-1:0] delta_t,
    output logic [TS_W-1:0]   dt_ticks,
    output logic              dt_start,
    output logic              busy,
    output logic              clamp_err,
    output logic              dup_err,
    output logic              ovr_err
);

    localparam logic [TS_W-1:0] MAX_D = TS_W'(DT_MAX_TICKS);

    ts_state_e         state;
    logic              have_prev;
    logic [TS_W-1:0]   prev_ts;
    logic [TS_W-1:0]   d_reg;
    logic [TS_W-1:0]   diff;
    logic [63:0]       fp_conv;
    logic [63:0]       fp_d;
    logic              mul_valid;
    logic              mul_finish;
    logic [63:0]       mul_y;

    // Modular subtraction makes counter wrap transparent
    assign diff      = meas_ts - prev_ts;
    assign busy      = (state != S_IDLE);
    assign mul_valid = (state == S_ISSUE);

    uint_to_fp64 #(
        .TS_W (TS_W)
    ) u_conv (
        .x (d_reg),
        .y (fp_conv)
    );

    fp_multiplier u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (mul_valid),
        .a      (fp_d),
        .b      (64'(TICK_SEC)),
        .finish (mul_finish),
        .result (mul_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            have_prev <= 1'b0;
            prev_ts   <= '0;
            d_reg     <= '0;
            fp_d      <= '0;
            delta_t   <= '0;
            dt_ticks  <= '0;
            dt_start  <= 1'b0;
            clamp_err <= 1'b0;
            dup_err   <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            dt_start  <= 1'b0;
            clamp_err <= 1'b0;
            dup_err   <= 1'b0;
            ovr_err   <= meas_valid && (state != S_IDLE);
            unique case (state)
                S_IDLE: begin
                    if (meas_valid) begin
                        if (!have_prev) begin
                            prev_ts   <= meas_ts;
                            have_prev <= 1'b1;
                        end else if (diff == '0) begin
                            dup_err <= 1'b1;
                        end else begin
                            if (diff > MAX_D) begin
                                d_reg     <= MAX_D;
                                clamp_err <= 1'b1;
                            end else begin
                                d_reg <= diff;
                            end
                            prev_ts <= meas_ts;
                            state   <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    fp_d  <= fp_conv;
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_finish) begin
                        delta_t  <= DWIDTH'(mul_y);
                        dt_ticks <= d_reg;
                        dt_start <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
